// File: rtl/machine_timer_unit.sv
// Machine timer / software-interrupt source (CLINT subset): 64-bit mtime with prescaler,
// 64-bit mtimecmp, msip, and a single-beat word bus with one-cycle registered response.
module machine_timer_unit #(
    parameter int TICK_DIV = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        BUS_VALID,
    input  logic        BUS_WRITE,
    input  logic [4:0]  BUS_ADDR,
    input  logic [31:0] BUS_WDATA,
    output logic        BUS_READY,
    output logic [31:0] BUS_RDATA,
    output logic        MTIP,
    output logic        MSIP,
    output logic [63:0] TIME_VALUE
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic          mtip_q, mtip_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          tick;
    logic          accept;
    logic          wr_en;
    logic [2:0]    reg_sel;
    logic [31:0]   read_word;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^BUS_ADDR[1:0];

    assign tick    = (prescaler_q == PRE_MAX);
    assign accept  = (state_q == IDLE) && BUS_VALID;
    assign wr_en   = accept && BUS_WRITE;
    assign reg_sel = BUS_ADDR[4:2];

    always_comb begin
        read_word = 32'h0;
        case (reg_sel)
            3'd0:    read_word = {31'h0, msip_q};
            3'd2:    read_word = mtime_q[31:0];
            3'd3:    read_word = mtime_q[63:32];
            3'd4:    read_word = mtimecmp_q[31:0];
            3'd5:    read_word = mtimecmp_q[63:32];
            default: read_word = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        rdata_d     = 32'h0;
        prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        mtip_d      = (mtime_q >= mtimecmp_q);

        case (state_q)
            IDLE: begin
                if (BUS_VALID) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    rdata_d = BUS_WRITE ? 32'h0 : read_word;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A bus write to mtime overrides that cycle's increment; the other half holds.
        if (wr_en) begin
            case (reg_sel)
                3'd0:    msip_d     = BUS_WDATA[0];
                3'd2:    mtime_d    = {mtime_q[63:32], BUS_WDATA};
                3'd3:    mtime_d    = {BUS_WDATA, mtime_q[31:0]};
                3'd4:    mtimecmp_d = {mtimecmp_q[63:32], BUS_WDATA};
                3'd5:    mtimecmp_d = {BUS_WDATA, mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            prescaler_q <= '0;
            mtime_q     <= 64'h0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            mtip_q      <= mtip_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
        end
    end

    assign BUS_READY  = ready_q;
    assign BUS_RDATA  = rdata_q;
    assign MTIP       = mtip_q;
    assign MSIP       = msip_q;
    assign TIME_VALUE = mtime_q;

endmodule
